// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared FSM encoding and direction constants for shift_sequencer
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response handshake bundle for shift_sequencer
// Optional macro SHIFT_SEQ_ROTATE_EN adds the req_rot request field.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_dir;
  logic [AMT_W-1:0] req_amt;
  logic [WIDTH-1:0] req_data;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             req_rot;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

`ifdef SHIFT_SEQ_ROTATE_EN
  modport master (
    output req_valid, req_dir, req_amt, req_data, req_rot, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_dir, req_amt, req_data, req_rot, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
`else
  modport master (
    output req_valid, req_dir, req_amt, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_dir, req_amt, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
`endif

endinterface

// File: rtl/shift_sequencer_step.sv
// rtl/shift_sequencer_step.sv - combinational one-position shift/rotate of a WIDTH-bit value
import shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 4
) (
  input  logic             dir,
  input  logic             rot,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in;
    if (dir == DIR_RIGHT) begin
      out = {rot & in[0], in[WIDTH-1:1]};
    end else begin
      out = {in[WIDTH-2:0], rot & in[WIDTH-1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle N-position shifter built from a single one-position step
// Optional macro SHIFT_SEQ_ROTATE_EN enables rotate mode via req_rot.
import shift_pkg::*;

module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;
  logic             rot_q;
  logic             req_rot;
  logic [AMT_W-1:0] eff_amt;
  logic [WIDTH-1:0] step_out;
  logic             accept;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign req_rot = bus.req_rot;
`else
  assign req_rot = 1'b0;
`endif

  // Rotation distance wraps (WIDTH is a power of 2); logical distance saturates at WIDTH.
  always_comb begin
    if (req_rot) begin
      eff_amt = bus.req_amt & AMT_W'(WIDTH - 1);
    end else if (bus.req_amt > AMT_W'(WIDTH)) begin
      eff_amt = AMT_W'(WIDTH);
    end else begin
      eff_amt = bus.req_amt;
    end
  end

  assign accept = (state == IDLE) && bus.req_valid;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .dir (dir_q),
    .rot (rot_q),
    .in  (data_q),
    .out (step_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid) state_n = SHIFT;
      SHIFT:   if (cnt == '0)     state_n = DONE;
      DONE:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.rsp_data  = data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt    <= '0;
      dir_q  <= DIR_LEFT;
      rot_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.req_data;
      cnt    <= eff_amt;
      dir_q  <= bus.req_dir;
      rot_q  <= req_rot;
    end else if (state == SHIFT && cnt != '0) begin
      data_q <= step_out;
      cnt    <= cnt - AMT_W'(1);
    end
  end

endmodule
